// File: rtl/axi_mm_pkg.sv
// Shared types for the AXI4 memory-mapped write slave: burst encodings,
// response codes and the write-path FSM states.
package axi_mm_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/axi_mm_ram.sv
// Word-addressed simple dual-port RAM: byte-enable write port and a registered
// read port; a read of a word written on the same edge returns the old value.
module axi_mm_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DSIZE = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DSIZE-1:0]         wdata,
  input  logic [DSIZE/8-1:0]       wbe,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DSIZE-1:0]         rdata
);

  localparam int unsigned NBYTES = DSIZE / 8;

  logic [DSIZE-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mm_wr_slave.sv
// AXI4 write slave terminating AW/W/B with one burst outstanding; accepted beats
// land in an internal RAM, which a side-band debug port can read back.
module axi_mm_wr_slave
  import axi_mm_pkg::*;
#(
  parameter int unsigned ASIZE  = 32,
  parameter int unsigned DSIZE  = 32,
  parameter int unsigned LSIZE  = 8,
  parameter int unsigned IDSIZE = 4,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [IDSIZE-1:0]        awid,
  input  logic [ASIZE-1:0]         awaddr,
  input  logic [LSIZE-1:0]         awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DSIZE-1:0]         wdata,
  input  logic [DSIZE/8-1:0]       wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [IDSIZE-1:0]        bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DSIZE-1:0]         dbg_data
);

  localparam int unsigned NBYTES = DSIZE / 8;
  localparam int unsigned SHIFT  = $clog2(NBYTES);
  localparam int unsigned IW     = $clog2(DEPTH);
  localparam int unsigned XW     = ASIZE + 1;

  state_e             state, state_next;
  logic [IDSIZE-1:0]  id_q;
  logic [ASIZE-1:0]   idx_q;
  logic [LSIZE-1:0]   len_q, cnt_q;
  burst_e             burst_q;
  logic               err_q;

  logic               aw_fire, w_fire, b_fire;
  logic               last_beat, wlast_bad, resp_load, aw_err;
  logic [ASIZE-1:0]   aw_idx;
  logic               ram_we;

  // AW-time legality: size must be one full word, only FIXED/INCR, and the
  // whole burst must stay inside the RAM.
  always_comb begin
    aw_idx = awaddr >> SHIFT;
    aw_err = 1'b0;
    if (awsize != 3'(SHIFT)) aw_err = 1'b1;
    if (awburst == BURST_WRAP || awburst == BURST_RSVD) aw_err = 1'b1;
    if (awburst == BURST_INCR &&
        (XW'(aw_idx) + XW'(awlen)) >= XW'(DEPTH)) aw_err = 1'b1;
    if (awburst == BURST_FIXED && aw_idx >= ASIZE'(DEPTH)) aw_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    aw_fire    = awvalid & awready;
    w_fire     = wvalid & wready;
    b_fire     = bvalid & bready;
    last_beat  = (cnt_q == len_q);
    wlast_bad  = (wlast != last_beat);
    resp_load  = 1'b0;
    ram_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (aw_fire) state_next = ST_DATA;
      end
      ST_DATA: begin
        ram_we = w_fire & ~err_q;
        if (w_fire && last_beat) begin
          resp_load  = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (b_fire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      state   <= state_next;
      awready <= (state_next == ST_IDLE);
      wready  <= (state_next == ST_DATA);
      bvalid  <= (state_next == ST_RESP);
      if (resp_load) begin
        bid   <= id_q;
        bresp <= (err_q | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Burst context: latched on AW, advanced per beat; a misplaced wlast poisons
  // the rest of the burst but the offending beat itself is still written.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= BURST_FIXED;
      err_q   <= 1'b0;
    end else if (aw_fire) begin
      id_q    <= awid;
      idx_q   <= aw_idx;
      len_q   <= awlen;
      cnt_q   <= '0;
      burst_q <= burst_e'(awburst);
      err_q   <= aw_err;
    end else if (w_fire) begin
      cnt_q <= cnt_q + LSIZE'(1);
      if (burst_q == BURST_INCR) idx_q <= idx_q + ASIZE'(1);
      if (wlast_bad) err_q <= 1'b1;
    end
  end

  axi_mm_ram #(
    .DEPTH (DEPTH),
    .DSIZE (DSIZE)
  ) u_ram (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .we    (ram_we),
    .waddr (idx_q[IW-1:0]),
    .wdata (wdata),
    .wbe   (wstrb),
    .raddr (dbg_addr),
    .rdata (dbg_data)
  );

endmodule
